muldiv_hilo_unit: RTL

//  Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
//  It sits beside the execute-stage ALU and takes the same rs/rt operands.
//  It runs MULT, MULTU, DIV and DIVU iteratively, and services MTHI/MTLO writes.
//  The ALU's MFHI/MFLO paths read hi/lo from this block.

---
 rtl/muldiv_hilo_unit_if.sv | 27 ++
 rtl/muldiv_hilo_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit_if.sv
// Bundle between the execute stage and the multiply/divide unit.
// The pipeline drives the request and MTHI/MTLO side and reads HI/LO and status.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// The operation runs on magnitudes for WIDTH cycles; signs are fixed up in a final cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_hilo_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   mag_b_reg;
  logic               b_sign_reg;
  logic               b_zero_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg;

  logic               start_ok;
  logic               in_signed;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic               is_div, is_signed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign start_ok  = bus.start && (state_reg == IDLE);
  assign in_signed = ~bus.op[0];
  assign mag_a_in  = (in_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign mag_b_in  = (in_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  assign is_div    = op_reg[1];
  assign is_signed = ~op_reg[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = CALC;
          count_next = CW'(WIDTH);
        end
      end
      CALC: begin
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // acc holds the product for multiplies and {remainder, quotient/dividend} for divides.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mag_b_reg} : '0);
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b_reg};
    acc_next  = acc_reg;
    if (is_div) begin
      if (!div_diff[WIDTH+1]) begin
        acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    quo        = acc_reg[WIDTH-1:0];
    rem        = acc_reg[2*WIDTH-1:WIDTH];
    prod_fixed = (is_signed && (a_reg[WIDTH-1] ^ b_sign_reg)) ? (~acc_reg + 1'b1) : acc_reg;
    fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
    fix_lo     = prod_fixed[WIDTH-1:0];
    if (is_div) begin
      if (b_zero_reg) begin
        fix_hi = a_reg;
        fix_lo = '1;
      end else begin
        fix_lo = (is_signed && (a_reg[WIDTH-1] ^ b_sign_reg)) ? (~quo + 1'b1) : quo;
        fix_hi = (is_signed && a_reg[WIDTH-1]) ? (~rem + 1'b1) : rem;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg  <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      mag_b_reg  <= '0;
      b_sign_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      acc_reg    <= '0;
    end else begin
      count_reg <= count_next;
      if (start_ok) begin
        op_reg     <= bus.op;
        a_reg      <= bus.a;
        mag_b_reg  <= mag_b_in;
        b_sign_reg <= bus.b[WIDTH-1];
        b_zero_reg <= (bus.b == '0);
        acc_reg    <= {{WIDTH{1'b0}}, mag_a_in};
      end else if (state_reg == CALC) begin
        acc_reg <= acc_next;
      end
    end
  end

  // An idle start takes priority over a same-cycle MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIX);
      if (state_reg == FIX) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end else if (state_reg == IDLE && !bus.start) begin
        if (bus.hi_we) hi_reg <= bus.wdata;
        if (bus.lo_we) lo_reg <= bus.wdata;
      end
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule
